bilinear_scale_ctrl: RTL and testbench
======================================

# bilinear_scale_ctrl

Configuration and coordinate-scheduling controller for the bilinear scaler datapath. At frame configuration it computes fixed-point scale factors (source dimension / destination dimension) with a sequential restoring divider. During the frame it maps each destination pixel coordinate, issued by the line-buffer stream controller, to a source integer index and fractional weight through a fixed 3-cycle pipeline. Its latency matches the datapath's adjust-mode (3-cycle) coordinate path.

## Interface
Parameters:
- INDEX_WIDTH, 16, width of destination/source pixel indices
- INT_WIDTH, 8, integer bits of scale factor (≤ INDEX_WIDTH)
- FIX_WIDTH, 12, fractional bits of scale factor and of frac outputs

Ports:
- clk_i  in  1  sole clock, all logic rising-edge
- rst_n_i  in  1  reset, asynchronous, active-low
- cfg_start_i  in  1  single-cycle request to latch dimensions and compute scale factors
- src_width_i, src_height_i  in  16 each  source image dimensions
- dest_width_i, dest_height_i  in  16 each  destination image dimensions
- cfg_busy_o  out  1  division in progress
- cfg_done_o  out  1  one-cycle pulse: configuration finished (success or error)
- cfg_err_o  out  1  last configuration rejected; held until next accepted cfg_start_i
- scale_factorx_o, scale_factory_o  out  INT_WIDTH+FIX_WIDTH  active scale factors, UQ(INT.FIX)
- destx_i, desty_i  in  INDEX_WIDTH  current destination coordinate from stream controller
- srcx_int_o, srcy_int_o  out  INDEX_WIDTH  mapped source integer index
- srcx_frac_o, srcy_frac_o  out  FIX_WIDTH  mapped fractional weight

## Operation
- FSM states: IDLE, DIV_X, DIV_Y, DONE, ERR.
- IDLE: cfg_start_i=1 latches all four dimensions into shadow registers.
  - If any dimension is zero, or src_width ≥ dest_width<<INT_WIDTH, or src_height ≥ dest_height<<INT_WIDTH (compare at 16+INT_WIDTH bits), go to ERR.
  - Otherwise go to DIV_X.
- DIV_X: restoring division of (src_width<<FIX_WIDTH) by dest_width, one quotient bit per cycle, MSB first. Produces Q = INT_WIDTH+FIX_WIDTH bits in exactly Q cycles, then goes to DIV_Y.
- DIV_Y: same division for height, Q cycles, then goes to DONE.
- DONE, 1 cycle:
  - Both quotients (truncated, no rounding) load into scale_factor{x,y}_o.
  - Shadow src dims become the active src dims used for clamping.
  - cfg_done_o=1, cfg_err_o=0. Next state IDLE.
- ERR, 1 cycle: cfg_done_o=1 and cfg_err_o set. Active scale factors and active src dims are unchanged. Next state IDLE.
- cfg_busy_o=1 in DIV_X, DIV_Y and DONE.
- cfg_start_i outside IDLE is ignored; no queueing.
- Mapping pipeline, free-running, independent of the FSM:
  - S1: register destx_i and desty_i.
  - S2: product = dest × active scale, full INDEX_WIDTH+INT_WIDTH+FIX_WIDTH bits, registered.
  - S3: int = product >> FIX_WIDTH, frac = product[FIX_WIDTH-1:0].
  - S3 clamp: if int ≥ active src dim − 1 (including any bits above INDEX_WIDTH), then int = src dim − 1 and frac = 0.
  - S3 output is registered to the src*_o ports.
- A scale-factor update during a frame takes effect on the next S2 computation. The stream controller issues cfg_start_i only between frames.

## Timing
- Reset values:
  - FSM in IDLE.
  - cfg_busy_o=0, cfg_done_o=0, cfg_err_o=0.
  - scale_factor{x,y}_o = 1<<FIX_WIDTH (1.0).
  - Active src dims = 1.
  - All pipeline registers and src*_o outputs = 0.
- Successful config: edge E samples cfg_start_i.
  - cfg_busy_o=1 from E.
  - cfg_done_o high for one cycle after edge E+2Q+1 (E+41 at defaults), coincident with the new scale factors appearing.
  - cfg_busy_o falls at E+2Q+2.
- Error config: cfg_done_o and cfg_err_o rise at E+1. cfg_done_o is high one cycle; cfg_busy_o never rises.
- Mapping latency: destx_i/desty_i sampled at edge N appear on src*_o after edge N+3. Throughput is one coordinate per cycle.
- Reset asserted mid-division: immediate return to reset values. The partial quotient is discarded, and no cfg_done_o is produced.

## Test plan
- Reset: hold rst_n_i low, drive random inputs -> scale_factor{x,y}_o=0x01000, all other outputs 0. Release reset -> outputs unchanged until stimulus.
- 640×480 -> 1280×960 config -> cfg_done_o exactly 41 edges after start, scale x=y=0x00800, err=0. destx=3 -> srcx_int=1, frac=0x800 three edges later.
- 100 -> 30 width config -> scale_factorx_o=0x03555. destx=29 -> srcx_int=96, srcx_frac=0xAA1.
- Clamp: src 4 -> dest 8 (scale 0x00800). destx=7 -> srcx_int=3, frac=0. destx=5 -> int 2, frac 0x800.
- Errors: dest_width=0 -> done+err at E+1, scale factors retain prior values. src_width=4096 with dest_width=8 -> err. A later valid start clears err.
- Robustness:
  - Second cfg_start_i pulsed 10 cycles into DIV_X -> ignored; single done at E+41.
  - rst_n_i pulsed low at E+20 -> busy drops immediately, no done, scale factors back to 0x01000.

Source files
------------

// File: rtl/bilinear_scale_ctrl_if.sv
// Bus between the line-buffer stream controller (master) and bilinear_scale_ctrl (slave):
// frame configuration handshake plus the per-pixel coordinate mapping path.
interface bilinear_scale_ctrl_if #(
    parameter int INDEX_WIDTH = 16,
    parameter int INT_WIDTH   = 8,
    parameter int FIX_WIDTH   = 12
);
    logic                           cfg_start_i;
    logic [INDEX_WIDTH-1:0]         src_width_i;
    logic [INDEX_WIDTH-1:0]         src_height_i;
    logic [INDEX_WIDTH-1:0]         dest_width_i;
    logic [INDEX_WIDTH-1:0]         dest_height_i;
    logic                           cfg_busy_o;
    logic                           cfg_done_o;
    logic                           cfg_err_o;
    logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_o;
    logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_o;
    logic [INDEX_WIDTH-1:0]         destx_i;
    logic [INDEX_WIDTH-1:0]         desty_i;
    logic [INDEX_WIDTH-1:0]         srcx_int_o;
    logic [INDEX_WIDTH-1:0]         srcy_int_o;
    logic [FIX_WIDTH-1:0]           srcx_frac_o;
    logic [FIX_WIDTH-1:0]           srcy_frac_o;

    modport master (
        output cfg_start_i, src_width_i, src_height_i, dest_width_i, dest_height_i,
        output destx_i, desty_i,
        input  cfg_busy_o, cfg_done_o, cfg_err_o, scale_factorx_o, scale_factory_o,
        input  srcx_int_o, srcy_int_o, srcx_frac_o, srcy_frac_o
    );

    modport slave (
        input  cfg_start_i, src_width_i, src_height_i, dest_width_i, dest_height_i,
        input  destx_i, desty_i,
        output cfg_busy_o, cfg_done_o, cfg_err_o, scale_factorx_o, scale_factory_o,
        output srcx_int_o, srcy_int_o, srcx_frac_o, srcy_frac_o
    );
endinterface

// File: rtl/bilinear_scale_ctrl.sv
// Bilinear scaler control: restoring divider that derives src/dest scale factors at frame
// configuration, plus a free-running pipeline mapping destination pixels to source index/weight.
module bilinear_scale_ctrl #(
    parameter int INDEX_WIDTH = 16,
    parameter int INT_WIDTH   = 8,
    parameter int FIX_WIDTH   = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    bilinear_scale_ctrl_if.slave bus
);
    localparam int Q  = INT_WIDTH + FIX_WIDTH;
    localparam int DW = INDEX_WIDTH + FIX_WIDTH;
    localparam int IW = INDEX_WIDTH + INT_WIDTH;
    localparam int PW = INDEX_WIDTH + Q;
    localparam int CW = $clog2(Q);
    localparam logic [Q-1:0]           SCALE_ONE = Q'(2 ** FIX_WIDTH);
    localparam logic [CW-1:0]          LAST_STEP = CW'(Q - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_INDEX = INDEX_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV_X,
        S_DIV_Y,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_busy;
    logic                   w_dims_bad;
    logic                   w_div_last;
    logic                   w_dividing;
    logic                   w_qbit;

    logic [INDEX_WIDTH-1:0] r_sh_src_w;
    logic [INDEX_WIDTH-1:0] r_sh_src_h;
    logic [INDEX_WIDTH-1:0] r_sh_dst_w;
    logic [INDEX_WIDTH-1:0] r_sh_dst_h;
    logic [INDEX_WIDTH-1:0] r_act_src_w;
    logic [INDEX_WIDTH-1:0] r_act_src_h;

    logic [INDEX_WIDTH-1:0] r_rem;
    logic [INDEX_WIDTH-1:0] w_rem_next;
    logic [INDEX_WIDTH-1:0] w_init_rem;
    logic [INDEX_WIDTH-1:0] w_divisor;
    logic [INDEX_WIDTH-1:0] w_load_src;
    logic [INDEX_WIDTH-1:0] w_diff;
    logic [INDEX_WIDTH:0]   w_trial;
    logic [DW-1:0]          w_dividend;
    logic [Q-1:0]           r_dvd;
    logic [Q-1:0]           w_init_dvd;
    logic [Q-1:0]           r_quo;
    logic [Q-1:0]           w_quo_next;
    logic [Q-1:0]           r_qx;
    logic [Q-1:0]           r_scale_x;
    logic [Q-1:0]           r_scale_y;
    logic [CW-1:0]          r_cnt;
    logic                   r_done;
    logic                   r_err;

    // A legal ratio keeps the quotient inside Q bits, so the divider can skip the top bits.
    assign w_dims_bad = (bus.src_width_i == '0) || (bus.src_height_i == '0)
                     || (bus.dest_width_i == '0) || (bus.dest_height_i == '0)
                     || (IW'(bus.src_width_i) >= {bus.dest_width_i, {INT_WIDTH{1'b0}}})
                     || (IW'(bus.src_height_i) >= {bus.dest_height_i, {INT_WIDTH{1'b0}}});

    assign w_dividing = (r_state == S_DIV_X) || (r_state == S_DIV_Y);
    assign w_div_last = (r_cnt == LAST_STEP);
    assign w_load_src = (r_state == S_IDLE) ? bus.src_width_i : r_sh_src_h;
    assign w_dividend = {w_load_src, {FIX_WIDTH{1'b0}}};
    assign w_init_rem = INDEX_WIDTH'(w_dividend[DW-1:Q]);
    assign w_init_dvd = w_dividend[Q-1:0];

    assign w_divisor  = (r_state == S_DIV_X) ? r_sh_dst_w : r_sh_dst_h;
    assign w_trial    = {r_rem, r_dvd[Q-1]};
    assign w_qbit     = (w_trial >= {1'b0, w_divisor});
    assign w_diff     = w_trial[INDEX_WIDTH-1:0] - w_divisor;
    assign w_rem_next = w_qbit ? w_diff : w_trial[INDEX_WIDTH-1:0];
    assign w_quo_next = {r_quo[Q-2:0], w_qbit};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Busy stays up through the done pulse of a successful configuration.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = (r_state == S_DIV_X) || (r_state == S_DIV_Y) || (r_state == S_DONE)
                || (r_done && !r_err);
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_start_i) begin
                    w_accept = 1'b1;
                    w_next   = w_dims_bad ? S_ERR : S_DIV_X;
                end
            end
            S_DIV_X: if (w_div_last) w_next = S_DIV_Y;
            S_DIV_Y: if (w_div_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sh_src_w  <= '0;
            r_sh_src_h  <= '0;
            r_sh_dst_w  <= '0;
            r_sh_dst_h  <= '0;
            r_act_src_w <= ONE_INDEX;
            r_act_src_h <= ONE_INDEX;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_quo       <= '0;
            r_qx        <= '0;
            r_cnt       <= '0;
            r_scale_x   <= SCALE_ONE;
            r_scale_y   <= SCALE_ONE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sh_src_w <= bus.src_width_i;
                r_sh_src_h <= bus.src_height_i;
                r_sh_dst_w <= bus.dest_width_i;
                r_sh_dst_h <= bus.dest_height_i;
                r_rem      <= w_init_rem;
                r_dvd      <= w_init_dvd;
                r_cnt      <= '0;
                r_err      <= 1'b0;
            end
            if (w_dividing) begin
                r_quo <= w_quo_next;
                if (w_div_last) begin
                    r_cnt <= '0;
                    r_rem <= w_init_rem;
                    r_dvd <= w_init_dvd;
                    if (r_state == S_DIV_X) begin
                        r_qx <= w_quo_next;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[Q-2:0], 1'b0};
                end
            end
            if (r_state == S_DONE) begin
                r_scale_x   <= r_qx;
                r_scale_y   <= r_quo;
                r_act_src_w <= r_sh_src_w;
                r_act_src_h <= r_sh_src_h;
                r_done      <= 1'b1;
                r_err       <= 1'b0;
            end
            if (r_state == S_ERR) begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
            end
        end
    end

    logic [INDEX_WIDTH-1:0] r_dx;
    logic [INDEX_WIDTH-1:0] r_dy;
    logic [PW-1:0]          r_px;
    logic [PW-1:0]          r_py;
    logic [IW-1:0]          w_ix;
    logic [IW-1:0]          w_iy;
    logic [INDEX_WIDTH-1:0] w_maxx;
    logic [INDEX_WIDTH-1:0] w_maxy;
    logic [INDEX_WIDTH-1:0] r_ix3;
    logic [INDEX_WIDTH-1:0] r_iy3;
    logic [FIX_WIDTH-1:0]   r_fx3;
    logic [FIX_WIDTH-1:0]   r_fy3;
    logic [INDEX_WIDTH-1:0] r_maxx3;
    logic [INDEX_WIDTH-1:0] r_maxy3;
    logic                   r_clx3;
    logic                   r_cly3;
    logic [INDEX_WIDTH-1:0] r_sx_int;
    logic [INDEX_WIDTH-1:0] r_sy_int;
    logic [FIX_WIDTH-1:0]   r_sx_frac;
    logic [FIX_WIDTH-1:0]   r_sy_frac;

    assign w_ix   = r_px[PW-1:FIX_WIDTH];
    assign w_iy   = r_py[PW-1:FIX_WIDTH];
    assign w_maxx = r_act_src_w - ONE_INDEX;
    assign w_maxy = r_act_src_h - ONE_INDEX;

    // The clamp compare is registered ahead of the select so the full-width product compare
    // gets its own cycle; this also lands the path on the datapath's 3-cycle adjust latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dx      <= '0;
            r_dy      <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_ix3     <= '0;
            r_iy3     <= '0;
            r_fx3     <= '0;
            r_fy3     <= '0;
            r_maxx3   <= '0;
            r_maxy3   <= '0;
            r_clx3    <= 1'b0;
            r_cly3    <= 1'b0;
            r_sx_int  <= '0;
            r_sy_int  <= '0;
            r_sx_frac <= '0;
            r_sy_frac <= '0;
        end else begin
            r_dx      <= bus.destx_i;
            r_dy      <= bus.desty_i;
            r_px      <= PW'(r_dx) * PW'(r_scale_x);
            r_py      <= PW'(r_dy) * PW'(r_scale_y);
            r_ix3     <= w_ix[INDEX_WIDTH-1:0];
            r_iy3     <= w_iy[INDEX_WIDTH-1:0];
            r_fx3     <= r_px[FIX_WIDTH-1:0];
            r_fy3     <= r_py[FIX_WIDTH-1:0];
            r_maxx3   <= w_maxx;
            r_maxy3   <= w_maxy;
            r_clx3    <= (w_ix >= IW'(w_maxx));
            r_cly3    <= (w_iy >= IW'(w_maxy));
            r_sx_int  <= r_clx3 ? r_maxx3 : r_ix3;
            r_sy_int  <= r_cly3 ? r_maxy3 : r_iy3;
            r_sx_frac <= r_clx3 ? '0 : r_fx3;
            r_sy_frac <= r_cly3 ? '0 : r_fy3;
        end
    end

    assign bus.cfg_busy_o      = w_busy;
    assign bus.cfg_done_o      = r_done;
    assign bus.cfg_err_o       = r_err;
    assign bus.scale_factorx_o = r_scale_x;
    assign bus.scale_factory_o = r_scale_y;
    assign bus.srcx_int_o      = r_sx_int;
    assign bus.srcy_int_o      = r_sy_int;
    assign bus.srcx_frac_o     = r_sx_frac;
    assign bus.srcy_frac_o     = r_sy_frac;
endmodule

// File: tb/tb_bilinear_scale_ctrl.sv
// Directed self-checking bench for bilinear_scale_ctrl: configuration timing, divider results,
// coordinate mapping with clamping, error handling and reset/restart robustness.
module tb_bilinear_scale_ctrl;
    localparam int INDEX_WIDTH = 16;
    localparam int INT_WIDTH   = 8;
    localparam int FIX_WIDTH   = 12;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    bilinear_scale_ctrl_if #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .INT_WIDTH  (INT_WIDTH),
        .FIX_WIDTH  (FIX_WIDTH)
    ) bus ();

    bilinear_scale_ctrl #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .INT_WIDTH  (INT_WIDTH),
        .FIX_WIDTH  (FIX_WIDTH)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_dims(input logic [15:0] sw, input logic [15:0] sh,
                              input logic [15:0] dw, input logic [15:0] dh);
        bus.src_width_i   = sw;
        bus.src_height_i  = sh;
        bus.dest_width_i  = dw;
        bus.dest_height_i = dh;
    endtask

    // Pulses start and returns the number of edges after the sampling edge until done is seen.
    task automatic run_config(input logic [15:0] sw, input logic [15:0] sh,
                              input logic [15:0] dw, input logic [15:0] dh,
                              output int lat, output logic err_seen, output logic busy_seen);
        drive_dims(sw, sh, dw, dh);
        bus.cfg_start_i = 1'b1;
        tick();
        bus.cfg_start_i = 1'b0;
        busy_seen = bus.cfg_busy_o;
        lat       = -1;
        err_seen  = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus.cfg_busy_o === 1'b1) busy_seen = 1'b1;
            if (bus.cfg_done_o === 1'b1) begin
                lat      = k;
                err_seen = bus.cfg_err_o;
                break;
            end
        end
    endtask

    task automatic map_settle(input logic [15:0] x, input logic [15:0] y);
        bus.destx_i = x;
        bus.desty_i = y;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [67:0] zeros;
        rst_n_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cfg_start_i = 1'($urandom);
            drive_dims(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            bus.destx_i = 16'($urandom);
            bus.desty_i = 16'($urandom);
            tick();
        end
        zeros = {bus.cfg_busy_o, bus.cfg_done_o, bus.cfg_err_o, bus.srcx_int_o, bus.srcx_frac_o,
                 bus.srcy_int_o, bus.srcy_frac_o, 5'b0};
        total++;
        if (zeros !== 68'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", zeros);
        end
        total++;
        if ({bus.scale_factorx_o, bus.scale_factory_o} !== {20'h01000, 20'h01000}) begin
            bad++;
            $display("[TB] FAIL reset_scale: got %h/%h expected 01000/01000",
                     bus.scale_factorx_o, bus.scale_factory_o);
        end
        bus.cfg_start_i = 1'b0;
        bus.destx_i     = 16'd123;
        bus.desty_i     = 16'd77;
        rst_n_i = 1'b1;
        repeat (6) tick();
        total++;
        if ({bus.cfg_busy_o, bus.cfg_done_o, bus.cfg_err_o, bus.srcx_int_o, bus.srcx_frac_o,
             bus.srcy_int_o, bus.srcy_frac_o, bus.scale_factorx_o} !== {3'b0, 56'h0, 20'h01000}) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: busy=%b done=%b err=%b sx=%h/%h sy=%h/%h scx=%h",
                     bus.cfg_busy_o, bus.cfg_done_o, bus.cfg_err_o, bus.srcx_int_o,
                     bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o, bus.scale_factorx_o);
        end
    endtask

    task automatic test_config_640();
        int   lat;
        logic err_seen;
        logic busy_seen;
        bus.destx_i = 16'd0;
        bus.desty_i = 16'd0;
        run_config(16'd640, 16'd480, 16'd1280, 16'd960, lat, err_seen, busy_seen);
        total++;
        if (lat !== 41) begin bad++; $display("[TB] FAIL cfg640_latency: got %0d expected 41", lat); end
        total++;
        if ({err_seen, busy_seen, bus.cfg_busy_o} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL cfg640_flags: err/busy_seen/busy got %b%b%b expected 011",
                     err_seen, busy_seen, bus.cfg_busy_o);
        end
        total++;
        if ({bus.scale_factorx_o, bus.scale_factory_o} !== {20'h00800, 20'h00800}) begin
            bad++;
            $display("[TB] FAIL cfg640_scale: got %h/%h expected 00800/00800",
                     bus.scale_factorx_o, bus.scale_factory_o);
        end
        tick();
        total++;
        if ({bus.cfg_done_o, bus.cfg_busy_o} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL cfg640_done_width: done/busy got %b%b expected 00",
                     bus.cfg_done_o, bus.cfg_busy_o);
        end
        bus.destx_i = 16'd3;
        bus.desty_i = 16'd5;
        repeat (3) tick();
        total++;
        if ({bus.srcx_int_o, bus.srcx_frac_o} !== {16'd0, 12'h000}) begin
            bad++;
            $display("[TB] FAIL map_latency_early: got %0d/%h expected 0/000",
                     bus.srcx_int_o, bus.srcx_frac_o);
        end
        tick();
        total++;
        if ({bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o}
            !== {16'd1, 12'h800, 16'd2, 12'h800}) begin
            bad++;
            $display("[TB] FAIL map_640: got x=%0d/%h y=%0d/%h expected x=1/800 y=2/800",
                     bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o);
        end
    endtask

    task automatic test_frac_100();
        int   lat;
        logic err_seen;
        logic busy_seen;
        run_config(16'd100, 16'd480, 16'd30, 16'd960, lat, err_seen, busy_seen);
        total++;
        if ({lat, err_seen} !== {32'd41, 1'b0}) begin
            bad++;
            $display("[TB] FAIL cfg100_done: lat=%0d err=%b expected 41/0", lat, err_seen);
        end
        total++;
        if ({bus.scale_factorx_o, bus.scale_factory_o} !== {20'h03555, 20'h00800}) begin
            bad++;
            $display("[TB] FAIL cfg100_scale: got %h/%h expected 03555/00800",
                     bus.scale_factorx_o, bus.scale_factory_o);
        end
        map_settle(16'd29, 16'd959);
        total++;
        if ({bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o}
            !== {16'd96, 12'hAA1, 16'd479, 12'h000}) begin
            bad++;
            $display("[TB] FAIL map_100: got x=%0d/%h y=%0d/%h expected x=96/aa1 y=479/000",
                     bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic err_seen;
        logic busy_seen;
        logic [15:0] exp_xi [8] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
        logic [11:0] exp_xf [8] = '{12'h0, 12'h800, 12'h0, 12'h800, 12'h0, 12'h800, 12'h0, 12'h0};
        logic [15:0] exp_yi [8] = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0};
        logic [11:0] exp_yf [8] = '{12'h0, 12'h0, 12'h800, 12'h0, 12'h800, 12'h0, 12'h800, 12'h0};
        run_config(16'd4, 16'd4, 16'd8, 16'd8, lat, err_seen, busy_seen);
        total++;
        if ({lat, err_seen, bus.scale_factorx_o, bus.scale_factory_o}
            !== {32'd41, 1'b0, 20'h00800, 20'h00800}) begin
            bad++;
            $display("[TB] FAIL cfg4_done: lat=%0d err=%b scale=%h/%h expected 41/0/00800/00800",
                     lat, err_seen, bus.scale_factorx_o, bus.scale_factory_o);
        end
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                bus.destx_i = 16'(c);
                bus.desty_i = 16'(7 - c);
            end
            tick();
            if (c >= 3) begin
                total++;
                if ({bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o}
                    !== {exp_xi[c-3], exp_xf[c-3], exp_yi[c-3], exp_yf[c-3]}) begin
                    bad++;
                    $display("[TB] FAIL stream_%0d: got x=%0d/%h y=%0d/%h expected x=%0d/%h y=%0d/%h",
                             c - 3, bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o,
                             exp_xi[c-3], exp_xf[c-3], exp_yi[c-3], exp_yf[c-3]);
                end
            end
        end
    endtask

    task automatic test_errors();
        int   lat;
        logic err_seen;
        logic busy_seen;
        run_config(16'd100, 16'd100, 16'd0, 16'd50, lat, err_seen, busy_seen);
        total++;
        if ({lat, err_seen, busy_seen} !== {32'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL err_zero_dim: lat=%0d err=%b busy_seen=%b expected 1/1/0",
                     lat, err_seen, busy_seen);
        end
        total++;
        if ({bus.scale_factorx_o, bus.scale_factory_o} !== {20'h00800, 20'h00800}) begin
            bad++;
            $display("[TB] FAIL err_scale_kept: got %h/%h expected 00800/00800",
                     bus.scale_factorx_o, bus.scale_factory_o);
        end
        tick();
        total++;
        if ({bus.cfg_done_o, bus.cfg_err_o, bus.cfg_busy_o} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL err_hold: done/err/busy got %b%b%b expected 010",
                     bus.cfg_done_o, bus.cfg_err_o, bus.cfg_busy_o);
        end
        run_config(16'd4096, 16'd10, 16'd8, 16'd10, lat, err_seen, busy_seen);
        total++;
        if ({lat, err_seen} !== {32'd1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL err_ratio_w: lat=%0d err=%b expected 1/1", lat, err_seen);
        end
        run_config(16'd2047, 16'd2048, 16'd8, 16'd8, lat, err_seen, busy_seen);
        total++;
        if ({lat, err_seen} !== {32'd1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL err_ratio_h_equal: lat=%0d err=%b expected 1/1", lat, err_seen);
        end
        map_settle(16'd7, 16'd7);
        total++;
        if ({bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o}
            !== {16'd3, 12'h0, 16'd3, 12'h0}) begin
            bad++;
            $display("[TB] FAIL err_src_kept: got x=%0d/%h y=%0d/%h expected x=3/000 y=3/000",
                     bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o);
        end
        run_config(16'd2047, 16'd8, 16'd8, 16'd8, lat, err_seen, busy_seen);
        total++;
        if ({lat, err_seen, bus.cfg_err_o} !== {32'd41, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL err_cleared: lat=%0d err=%b err_o=%b expected 41/0/0",
                     lat, err_seen, bus.cfg_err_o);
        end
        total++;
        if ({bus.scale_factorx_o, bus.scale_factory_o} !== {20'hFFE00, 20'h01000}) begin
            bad++;
            $display("[TB] FAIL max_ratio_scale: got %h/%h expected ffe00/01000",
                     bus.scale_factorx_o, bus.scale_factory_o);
        end
        map_settle(16'd1, 16'd3);
        total++;
        if ({bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o}
            !== {16'd255, 12'hE00, 16'd3, 12'h0}) begin
            bad++;
            $display("[TB] FAIL map_max_ratio: got x=%0d/%h y=%0d/%h expected x=255/e00 y=3/000",
                     bus.srcx_int_o, bus.srcx_frac_o, bus.srcy_int_o, bus.srcy_frac_o);
        end
    endtask

    task automatic test_robust_restart();
        int done_count = 0;
        int first_done = -1;
        drive_dims(16'd640, 16'd480, 16'd1280, 16'd960);
        bus.cfg_start_i = 1'b1;
        tick();
        bus.cfg_start_i = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.cfg_done_o === 1'b1) begin
                done_count++;
                if (first_done < 0) first_done = k;
            end
            if (k == 9) begin
                drive_dims(16'd100, 16'd480, 16'd30, 16'd960);
                bus.cfg_start_i = 1'b1;
            end
            if (k == 10) bus.cfg_start_i = 1'b0;
        end
        total++;
        if ({done_count, first_done} !== {32'd1, 32'd41}) begin
            bad++;
            $display("[TB] FAIL restart_ignored: dones=%0d first=%0d expected 1/41",
                     done_count, first_done);
        end
        total++;
        if ({bus.scale_factorx_o, bus.scale_factory_o} !== {20'h00800, 20'h00800}) begin
            bad++;
            $display("[TB] FAIL restart_scale: got %h/%h expected 00800/00800",
                     bus.scale_factorx_o, bus.scale_factory_o);
        end
    endtask

    task automatic test_reset_mid_div();
        int done_count = 0;
        drive_dims(16'd100, 16'd480, 16'd30, 16'd960);
        bus.cfg_start_i = 1'b1;
        tick();
        bus.cfg_start_i = 1'b0;
        repeat (20) tick();
        total++;
        if (bus.cfg_busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL middiv_busy: got %b expected 1", bus.cfg_busy_o);
        end
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({bus.cfg_busy_o, bus.cfg_done_o, bus.scale_factorx_o, bus.scale_factory_o}
            !== {2'b00, 20'h01000, 20'h01000}) begin
            bad++;
            $display("[TB] FAIL middiv_reset: busy=%b done=%b scale=%h/%h expected 0/0/01000/01000",
                     bus.cfg_busy_o, bus.cfg_done_o, bus.scale_factorx_o, bus.scale_factory_o);
        end
        repeat (2) tick();
        rst_n_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bus.cfg_done_o === 1'b1) done_count++;
        end
        total++;
        if ({done_count, bus.cfg_busy_o, bus.scale_factorx_o} !== {32'd0, 1'b0, 20'h01000}) begin
            bad++;
            $display("[TB] FAIL middiv_no_done: dones=%0d busy=%b scalex=%h expected 0/0/01000",
                     done_count, bus.cfg_busy_o, bus.scale_factorx_o);
        end
    endtask

    initial begin
        bus.cfg_start_i = 1'b0;
        drive_dims(16'd0, 16'd0, 16'd0, 16'd0);
        bus.destx_i = 16'd0;
        bus.desty_i = 16'd0;
        test_reset();
        test_config_640();
        test_frac_100();
        test_back_to_back();
        test_errors();
        test_robust_restart();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
